// File: rtl/keystream_gen.sv
// Keystream generator: replicates a multi-byte key across a message-wide
// register one byte per cycle, then advances it on each accepted transfer.
`timescale 1ns/1ps
module keystream_gen #(
   parameter int MSG_BYTES = 16,
   parameter int KEY_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_load,
   input  logic [8*KEY_BYTES-1:0] key_in,
   input  logic [1:0]             mode,
   input  logic                   out_ready,
   output logic [8*MSG_BYTES-1:0] out,
   output logic                   out_valid,
   output logic                   busy,
   output logic [15:0]            step_count,
   output logic [1:0]             fsm_state
);

   localparam int FW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;

   logic [1:0]             state;
   logic [8*KEY_BYTES-1:0] key_reg;
   logic [8*MSG_BYTES-1:0] out_reg;
   logic [FW-1:0]          fill_cnt;
   logic [KW-1:0]          key_idx;
   logic [15:0]            steps;

   // Handshake: a transfer is any cycle with out_valid && out_ready; out_valid
   // stays high in READY so the consumer sees a continuous stream.
   function automatic logic [8*MSG_BYTES-1:0] advance(
      input logic [8*MSG_BYTES-1:0] w,
      input logic [1:0]             m
   );
      logic [8*MSG_BYTES-1:0] r;
      logic [7:0]             b;
      r = w;
      case (m)
         2'd1: r = {w[8*MSG_BYTES-9:0], w[8*MSG_BYTES-1 -: 8]};
         2'd2: r = {w[7:0], w[8*MSG_BYTES-1:8]};
         2'd3: begin
            for (int i = 0; i < MSG_BYTES; i++) begin
               b = w[8*i +: 8];
               r[8*i +: 8] = {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
            end
         end
         default: r = w;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         key_reg  <= '0;
         out_reg  <= '0;
         fill_cnt <= '0;
         key_idx  <= '0;
         steps    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (key_load) begin
                  key_reg  <= key_in;
                  out_reg  <= '0;
                  fill_cnt <= '0;
                  key_idx  <= '0;
                  state    <= S_FILL;
               end
            end
            S_FILL: begin
               if (key_load) begin
                  key_reg  <= key_in;
                  out_reg  <= '0;
                  fill_cnt <= '0;
                  key_idx  <= '0;
               end else begin
                  out_reg[8*int'(fill_cnt) +: 8] <= key_reg[8*int'(key_idx) +: 8];
                  // key_idx tracks fill_cnt mod KEY_BYTES without a divider
                  key_idx <= (key_idx == KW'(KEY_BYTES-1)) ? '0 : key_idx + 1'b1;
                  if (fill_cnt == FW'(MSG_BYTES-1)) begin
                     fill_cnt <= '0;
                     steps    <= '0;
                     state    <= S_READY;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
            end
            S_READY: begin
               if (key_load) begin
                  key_reg  <= key_in;
                  out_reg  <= '0;
                  fill_cnt <= '0;
                  key_idx  <= '0;
                  state    <= S_FILL;
               end else if (out_ready) begin
                  out_reg <= advance(out_reg, mode);
                  steps   <= steps + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign out        = out_reg;
   assign out_valid  = (state == S_READY);
   assign busy       = (state == S_FILL);
   assign step_count = steps;
   assign fsm_state  = state;

endmodule

// File: tb/tb_keystream_gen.sv
// Self-checking bench for keystream_gen (MSG_BYTES=8, KEY_BYTES=4) against a
// byte-array reference model.
`timescale 1ns/1ps
module tb_keystream_gen;

   localparam int N = 8;
   localparam int K = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          key_load = 1'b0;
   logic [8*K-1:0] key_in = '0;
   logic [1:0]    mode = 2'd0;
   logic          out_ready = 1'b0;
   logic [8*N-1:0] out;
   logic          out_valid;
   logic          busy;
   logic [15:0]   step_count;
   logic [1:0]    fsm_state;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_b [N];
   int         exp_steps = 0;

   always #5 clk = ~clk;

   keystream_gen #(.MSG_BYTES(N), .KEY_BYTES(K)) dut (
      .clk        (clk),
      .reset      (reset),
      .key_load   (key_load),
      .key_in     (key_in),
      .mode       (mode),
      .out_ready  (out_ready),
      .out        (out),
      .out_valid  (out_valid),
      .busy       (busy),
      .step_count (step_count),
      .fsm_state  (fsm_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_fill(input logic [8*K-1:0] key);
      for (int i = 0; i < N; i++) exp_b[i] = key[8*(i % K) +: 8];
      exp_steps = 0;
   endtask

   task automatic model_advance(input logic [1:0] m);
      logic [7:0] tmp [N];
      for (int i = 0; i < N; i++) tmp[i] = exp_b[i];
      for (int i = 0; i < N; i++) begin
         case (m)
            2'd1: exp_b[i] = tmp[(i + N - 1) % N];
            2'd2: exp_b[i] = tmp[(i + 1) % N];
            2'd3: exp_b[i] = 8'((int'(tmp[i]) * 2) % 256) ^ ((tmp[i] >= 8'h80) ? 8'h1D : 8'h00);
            default: exp_b[i] = tmp[i];
         endcase
      end
      exp_steps = (exp_steps + 1) % 65536;
   endtask

   function automatic logic [8*N-1:0] exp_word();
      logic [8*N-1:0] r;
      for (int i = 0; i < N; i++) r[8*i +: 8] = exp_b[i];
      return r;
   endfunction

   task automatic do_fill(input logic [8*K-1:0] key);
      key_in   = key;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (N) tick();
      model_fill(key);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      key_in = 32'h12345678;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || step_count !== 16'd0 || fsm_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_values: out=%h valid=%b busy=%b step=%0d state=%0d, required all zero",
                  out, out_valid, busy, step_count, fsm_state);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_fill();
      logic [31:0]   key;
      logic [8*N-1:0] part;
      key = 32'hA1B2C3D4;
      key_in = key;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || out !== '0) begin
         errors++;
         $display("FAIL fill_start: busy=%b valid=%b out=%h, required busy=1 valid=0 out=0", busy, out_valid, out);
      end
      for (int k = 1; k <= N; k++) begin
         tick();
         part = '0;
         for (int j = 0; j < k; j++) part[8*j +: 8] = key[8*(j % K) +: 8];
         checks++;
         if (out !== part || busy !== (k < N) || out_valid !== (k == N)) begin
            errors++;
            $display("FAIL fill_step%0d: out=%h busy=%b valid=%b, required out=%h busy=%b valid=%b",
                     k, out, busy, out_valid, part, (k < N), (k == N));
         end
      end
      checks++;
      if (out !== 64'hA1B2C3D4A1B2C3D4 || step_count !== 16'd0) begin
         errors++;
         $display("FAIL fill_word: out=%h step=%0d, required a1b2c3d4a1b2c3d4 step=0", out, step_count);
      end
      model_fill(key);
   endtask

   task automatic test_rotations();
      mode = 2'd1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out !== 64'hB2C3D4A1B2C3D4A1 || step_count !== 16'd1) begin
         errors++;
         $display("FAIL rol: out=%h step=%0d, required b2c3d4a1b2c3d4a1 step=1", out, step_count);
      end
      mode = 2'd2;
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      checks++;
      if (out !== 64'hD4A1B2C3D4A1B2C3 || step_count !== 16'd3) begin
         errors++;
         $display("FAIL ror: out=%h step=%0d, required d4a1b2c3d4a1b2c3 step=3", out, step_count);
      end
   endtask

   task automatic test_lfsr_stall();
      do_fill(32'h0080A100);
      mode = 2'd3;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out !== 64'h001D5F00001D5F00 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL lfsr: out=%h valid=%b, required 001d5f00001d5f00 valid=1", out, out_valid);
      end
      for (int c = 0; c < 5; c++) begin
         mode = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if (out !== 64'h001D5F00001D5F00 || step_count !== 16'd1) begin
            errors++;
            $display("FAIL stall%0d: out=%h step=%0d, required 001d5f00001d5f00 step=1", c, out, step_count);
         end
      end
   endtask

   task automatic test_priority_restart();
      logic [31:0] k1, k2;
      logic [8*N-1:0] want;
      k1 = $urandom;
      k2 = $urandom;
      key_in = k1;
      key_load = 1'b1;
      out_ready = 1'b1;
      mode = 2'd1;
      tick();
      key_load = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || out !== '0) begin
         errors++;
         $display("FAIL priority: valid=%b busy=%b out=%h, required valid=0 busy=1 out=0", out_valid, busy, out);
      end
      repeat (3) tick();
      key_in = k2;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      checks++;
      if (out !== '0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_clear: out=%h busy=%b, required out=0 busy=1", out, busy);
      end
      for (int c = 1; c <= N; c++) begin
         tick();
         checks++;
         if (out_valid !== (c == N)) begin
            errors++;
            $display("FAIL restart_valid%0d: valid=%b, required %b", c, out_valid, (c == N));
         end
      end
      model_fill(k2);
      want = exp_word();
      checks++;
      if (out !== want) begin
         errors++;
         $display("FAIL restart_word: out=%h, required %h", out, want);
      end
   endtask

   task automatic test_random();
      do_fill($urandom);
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            out_ready = 1'($urandom_range(0, 1));
            do_fill($urandom);
         end else begin
            mode = 2'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (out_ready) model_advance(mode);
         end
         checks++;
         if (out !== exp_word() || step_count !== 16'(exp_steps) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL random%0d: out=%h step=%0d valid=%b, required out=%h step=%0d valid=1",
                     c, out, step_count, out_valid, exp_word(), exp_steps);
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [8*N-1:0] saved;
      do_fill($urandom);
      saved = exp_word();
      mode = 2'd0;
      out_ready = 1'b1;
      for (int c = 0; c < 65536; c++) begin
         tick();
         model_advance(2'd0);
         if (c == 65534) begin
            checks++;
            if (step_count !== 16'hFFFF) begin
               errors++;
               $display("FAIL wrap_top: step=%0d, required 65535", step_count);
            end
         end
      end
      out_ready = 1'b0;
      checks++;
      if (step_count !== 16'd0 || out !== saved) begin
         errors++;
         $display("FAIL wrap: step=%0d out=%h, required step=0 out=%h", step_count, out, saved);
      end
   endtask

   task automatic test_midfill_reset();
      key_in = $urandom;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || step_count !== 16'd0) begin
         errors++;
         $display("FAIL midfill_reset: out=%h valid=%b busy=%b step=%0d, required all zero",
                  out, out_valid, busy, step_count);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset%0d: valid=%b busy=%b, required 0 0", c, out_valid, busy);
         end
      end
   endtask

   initial begin
      #1_500_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      test_reset();
      test_fill();
      test_rotations();
      test_lfsr_stall();
      test_priority_restart();
      test_random();
      test_wrap();
      test_midfill_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
